if_id_register: RTL and testbench
=================================

# if_id_register

IF/ID pipeline register for the five-stage MIPS datapath. Captures the fetched instruction and its PC+4 at each clock edge, holds them under a stall, replaces them with a bubble on a flush, and presents the decoded instruction fields to the decode stage. Its `id_immediate` and `id_extension_type` outputs drive the 16-bit immediate input and the zero/sign select of the extension unit directly.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_instruction` in 32: instruction word from fetch.
- `if_pc_plus4` in 32: PC+4 of that instruction.
- `if_valid` in 1: fetch slot holds a real instruction.
- `stall` in 1: hold current contents (load-use hazard).
- `flush` in 1: replace contents with a bubble (taken branch or jump).
- `id_instruction` out 32: registered instruction.
- `id_pc_plus4` out 32: registered PC+4.
- `id_valid` out 1: registered valid.
- `id_opcode` out 6, `id_rs` out 5, `id_rt` out 5, `id_rd` out 5, `id_shamt` out 5, `id_funct` out 6: fields [31:26], [25:21], [20:16], [15:11], [10:6], [5:0] of `id_instruction`.
- `id_immediate` out 16: `id_instruction[15:0]`.
- `id_jump_target` out 26: `id_instruction[25:0]`.
- `id_extension_type` out 1: 0 = zero extension, 1 = sign extension.
- `stall_cycles` out 32: stall performance counter. Present only with `IF_ID_STALL_COUNTER_EN`.

## Operation
- State: `instr_q[31:0]`, `pc_q[31:0]`, `valid_q`, and optionally `stall_cnt_q[31:0]`.
- Per-edge priority: reset > flush > stall > load.
  - **reset** (`rst_n`=0, asynchronous): `instr_q`=0, `pc_q`=0, `valid_q`=0, `stall_cnt_q`=0.
  - **flush**=1: `instr_q`=0x00000000 (NOP, sll $0,$0,0), `pc_q`=0, `valid_q`=0. This applies even when `stall`=1.
  - **stall**=1, flush=0: all registers hold.
  - **load** (otherwise): `instr_q`=`if_instruction`, `pc_q`=`if_pc_plus4`, `valid_q`=`if_valid`.
- Loading with `if_valid`=0 still captures the instruction and PC; downstream stages must gate on `id_valid`.
- Field outputs are pure combinational slices of `instr_q`. They carry no extra register stage.
- `id_extension_type` is combinational from `instr_q[31:26]`:
  - 0 for ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F.
  - 1 for every other opcode, including the bubble (opcode 0).
- No state machine beyond this register; the only mode is hold versus load versus bubble.

## Timing
- Latency is one cycle: inputs sampled at edge N are visible on all `id_*` outputs after edge N.
- `stall` and `flush` are sampled on the same edge as the data. There is no lookahead and no registered control.
- Decode outputs settle in the same cycle as `instr_q`.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - Outputs then read: `id_instruction`=0, `id_valid`=0, `id_extension_type`=1, `stall_cycles`=0.
- Reset deassertion is synchronized externally. The first load happens at the first rising edge with `rst_n`=1.

## Configuration
- Macro: `IF_ID_STALL_COUNTER_EN`.
- **Defined:**
  - Port `stall_cycles` and register `stall_cnt_q` exist.
  - The counter increments by 1 on each edge where `stall`=1 and `flush`=0.
  - It saturates at 0xFFFFFFFF; no wrap-around.
  - It is cleared only by reset.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then load: `rst_n` low, then high, then drive `if_instruction`=0x2128FFFF (ADDI), `if_pc_plus4`=0x00400004, `if_valid`=1 → next cycle `id_rs`=9, `id_rt`=8, `id_immediate`=0xFFFF, `id_extension_type`=1, `id_valid`=1.
- Zero-extend opcode: load 0x3128FFFF (ANDI) → `id_extension_type`=0, `id_immediate`=0xFFFF.
- Stall hold: with 0x2128FFFF held, drive `stall`=1 for 3 cycles while `if_instruction`=0x8D090004 → outputs unchanged; `stall_cycles`=3 (macro defined); after release, `id_opcode`=0x23.
- Flush beats stall: `stall`=1 and `flush`=1 together → `id_instruction`=0, `id_valid`=0, `id_pc_plus4`=0; `stall_cycles` unchanged.
- Async reset mid-stream: pull `rst_n` low between clock edges → `id_valid`=0 and `id_instruction`=0 before the next edge.
- Counter saturation (macro defined): force `stall_cnt_q`=0xFFFFFFFE, stall 3 cycles → `stall_cycles`=0xFFFFFFFF.

Source files
------------

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures fetched instruction + PC+4 and slices decode fields for ID.
// Latency: one cycle from if_* inputs to all id_* outputs; field decode is combinational off the register.
// Backpressure: stall holds contents, flush inserts a NOP bubble (flush wins); IF_ID_STALL_COUNTER_EN adds stall_cycles.
module if_id_register (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_instruction,
  input  logic [31:0] if_pc_plus4,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_immediate,
  output logic [25:0] id_jump_target,
`ifdef IF_ID_STALL_COUNTER_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        id_extension_type
);

  // All-zero word decodes as sll $0,$0,0, so it doubles as the bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;

  // Pipeline register: flush beats stall, stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      // Invalid slots are still captured; ID gates on id_valid.
      instr_q <= if_instruction;
      pc_q    <= if_pc_plus4;
      valid_q <= if_valid;
    end
  end

`ifdef IF_ID_STALL_COUNTER_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of edges that actually held the register (a flush does not count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0;
    end else if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

  assign id_instruction = instr_q;
  assign id_pc_plus4    = pc_q;
  assign id_valid       = valid_q;
  assign id_opcode      = instr_q[31:26];
  assign id_rs          = instr_q[25:21];
  assign id_rt          = instr_q[20:16];
  assign id_rd          = instr_q[15:11];
  assign id_shamt       = instr_q[10:6];
  assign id_funct       = instr_q[5:0];
  assign id_immediate   = instr_q[15:0];
  assign id_jump_target = instr_q[25:0];

  // Logical immediates and LUI zero-extend; everything else (bubble included) sign-extends.
  always_comb begin
    id_extension_type = 1'b1;
    case (instr_q[31:26])
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: id_extension_type = 1'b0;
      default:                          id_extension_type = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_if_id_register.sv
module tb_if_id_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        stall;
  logic        flush;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_immediate;
  logic [25:0] id_jump_target;
  logic        id_extension_type;
`ifdef IF_ID_STALL_COUNTER_EN
  logic [31:0] stall_cycles;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  if_id_register dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .if_instruction    (if_instruction),
    .if_pc_plus4       (if_pc_plus4),
    .if_valid          (if_valid),
    .stall             (stall),
    .flush             (flush),
    .id_instruction    (id_instruction),
    .id_pc_plus4       (id_pc_plus4),
    .id_valid          (id_valid),
    .id_opcode         (id_opcode),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_rd             (id_rd),
    .id_shamt          (id_shamt),
    .id_funct          (id_funct),
    .id_immediate      (id_immediate),
    .id_jump_target    (id_jump_target),
`ifdef IF_ID_STALL_COUNTER_EN
    .stall_cycles      (stall_cycles),
`endif
    .id_extension_type (id_extension_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1ns past it; inputs change only here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic vld);
    if_instruction = instr;
    if_pc_plus4    = pc;
    if_valid       = vld;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    #1;
    check("rst_instr", id_instruction, 32'h0);
    check("rst_pc", id_pc_plus4, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_ext", {31'h0, id_extension_type}, 32'h1);
`ifdef IF_ID_STALL_COUNTER_EN
    check("rst_stall_cnt", stall_cycles, 32'h0);
`endif
    step();
    step();
    check("rst_hold_instr", id_instruction, 32'h0);
    rst_n = 1'b1;

    // ADDI $8,$9,-1
    drive(32'h2128_FFFF, 32'h0040_0004, 1'b1);
    step();
    check("addi_rs", {27'h0, id_rs}, 32'd9);
    check("addi_rt", {27'h0, id_rt}, 32'd8);
    check("addi_imm", {16'h0, id_immediate}, 32'h0000_FFFF);
    check("addi_ext", {31'h0, id_extension_type}, 32'h1);
    check("addi_valid", {31'h0, id_valid}, 32'h1);
    check("addi_opcode", {26'h0, id_opcode}, 32'h08);
    check("addi_pc", id_pc_plus4, 32'h0040_0004);

    // ANDI zero-extends
    drive(32'h3128_FFFF, 32'h0040_0008, 1'b1);
    step();
    check("andi_ext", {31'h0, id_extension_type}, 32'h0);
    check("andi_imm", {16'h0, id_immediate}, 32'h0000_FFFF);

    // LUI $1,0xABCD zero-extends
    drive(32'h3C01_ABCD, 32'h0040_000C, 1'b1);
    step();
    check("lui_ext", {31'h0, id_extension_type}, 32'h0);
    check("lui_imm", {16'h0, id_immediate}, 32'h0000_ABCD);

    // add $8,$9,$10
    drive(32'h012A_4020, 32'h0040_0010, 1'b1);
    step();
    check("add_rd", {27'h0, id_rd}, 32'd8);
    check("add_funct", {26'h0, id_funct}, 32'h20);
    check("add_ext", {31'h0, id_extension_type}, 32'h1);

    // sll $8,$9,2
    drive(32'h0009_4080, 32'h0040_0014, 1'b1);
    step();
    check("sll_shamt", {27'h0, id_shamt}, 32'd2);
    check("sll_rt", {27'h0, id_rt}, 32'd9);

    // j 0x0100004
    drive(32'h0810_0004, 32'h0040_0018, 1'b1);
    step();
    check("j_target", {6'h0, id_jump_target}, 32'h0010_0004);
    check("j_opcode", {26'h0, id_opcode}, 32'h02);

    // Stall: hold ADDI for 3 edges while fetch presents LW
    drive(32'h2128_FFFF, 32'h0040_0004, 1'b1);
    step();
    drive(32'h8D09_0004, 32'h0040_0008, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", id_instruction, 32'h2128_FFFF);
      check("stall_pc", id_pc_plus4, 32'h0040_0004);
    end
`ifdef IF_ID_STALL_COUNTER_EN
    check("stall_cnt3", stall_cycles, 32'd3);
`endif
    stall = 1'b0;
    step();
    check("release_opcode", {26'h0, id_opcode}, 32'h23);
    check("release_pc", id_pc_plus4, 32'h0040_0008);
`ifdef IF_ID_STALL_COUNTER_EN
    check("release_cnt", stall_cycles, 32'd3);
`endif

    // Invalid slot still captures instruction and PC
    drive(32'h1111_1111, 32'h0040_0020, 1'b0);
    step();
    check("inv_valid", {31'h0, id_valid}, 32'h0);
    check("inv_instr", id_instruction, 32'h1111_1111);
    check("inv_pc", id_pc_plus4, 32'h0040_0020);

    // Flush beats stall
    drive(32'h2128_FFFF, 32'h0040_0004, 1'b1);
    step();
    drive(32'h8D09_0004, 32'h0040_0008, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    step();
    check("flush_instr", id_instruction, 32'h0);
    check("flush_valid", {31'h0, id_valid}, 32'h0);
    check("flush_pc", id_pc_plus4, 32'h0);
    check("flush_ext", {31'h0, id_extension_type}, 32'h1);
`ifdef IF_ID_STALL_COUNTER_EN
    check("flush_cnt", stall_cycles, 32'd3);
`endif
    stall = 1'b0;
    flush = 1'b0;

    // Async reset between edges
    drive(32'h2128_FFFF, 32'h0040_0004, 1'b1);
    step();
    check("pre_rst_valid", {31'h0, id_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, id_valid}, 32'h0);
    check("async_rst_instr", id_instruction, 32'h0);
    check("async_rst_ext", {31'h0, id_extension_type}, 32'h1);
`ifdef IF_ID_STALL_COUNTER_EN
    check("async_rst_cnt", stall_cycles, 32'h0);
`endif
    step();
    check("in_rst_no_load", id_instruction, 32'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_load", id_instruction, 32'h2128_FFFF);

`ifdef IF_ID_STALL_COUNTER_EN
    // Saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    stall = 1'b1;
    step();
    check("sat_cnt1", stall_cycles, 32'hFFFF_FFFF);
    step();
    step();
    check("sat_cnt3", stall_cycles, 32'hFFFF_FFFF);
    stall = 1'b0;
`endif

    step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
